fir_coeff_receiver: RTL and testbench

Coefficient-load responder for the transposed FIR datapath. It accepts the split-coefficient stream (`cin_hi`/`cin_lo` word pairs presented while `load` is low), assembles each pair into a signed 2×WIDTH coefficient and stages it in shadow registers. On the rising of `load` it commits the full set atomically to the active bank that drives the tap multipliers. It sits between the coefficient source (bench driver or host loader) and the FIR multiplier array. It also flags short and overlong load sequences.

---
 rtl/fir_coeff_receiver.sv | 125 ++++++++++++
 tb/tb_fir_coeff_receiver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_receiver.sv
// Coefficient-load responder: assembles {cin_hi, cin_lo} pairs into shadow registers and
// commits the whole set to the active tap bank when load rises after a complete sequence.
module fir_coeff_receiver #(
   parameter int unsigned COEFF_SIZE = 4,
   parameter int unsigned WIDTH      = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 load,
   input  logic                                 cin_valid,
   input  logic [WIDTH-1:0]                     cin_hi,
   input  logic [WIDTH-1:0]                     cin_lo,
   input  logic                                 err_clr,
   output logic [COEFF_SIZE*2*WIDTH-1:0]        coeff_flat,
   output logic                                 coeff_ready,
   output logic [$clog2(COEFF_SIZE+1)-1:0]      word_count,
   output logic                                 short_err,
   output logic                                 ovf_err
);

   localparam int unsigned CoeffW = 2 * WIDTH;
   localparam int unsigned CntW   = $clog2(COEFF_SIZE + 1);
   localparam int unsigned BankW  = COEFF_SIZE * CoeffW;
   localparam logic [CntW-1:0] LastCnt = CntW'(COEFF_SIZE - 1);

   typedef enum logic [1:0] {StLoad, StFull, StRun, StError} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   word_count_q, word_count_d;
   logic [BankW-1:0]  shadow_q, shadow_d;
   logic [BankW-1:0]  active_q, active_d;
   logic              ready_q, ready_d;
   logic              short_q, short_d;
   logic              ovf_q, ovf_d;
   logic              short_set, ovf_set;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StLoad;
      end else begin
         state_q <= state_d;
      end
   end

   // load has priority over cin_valid in every state
   always_comb begin
      state_d = state_q;
      case (state_q)
         StLoad: begin
            if (load) begin
               state_d = StError;
            end else if (cin_valid && (word_count_q == LastCnt)) begin
               state_d = StFull;
            end
         end
         StFull:  if (load)  state_d = StRun;
         StRun:   if (!load) state_d = StLoad;
         StError: if (!load) state_d = StLoad;
         default: state_d = StLoad;
      endcase
   end

   always_comb begin
      word_count_d = word_count_q;
      shadow_d     = shadow_q;
      active_d     = active_q;
      ready_d      = ready_q;
      short_set    = 1'b0;
      ovf_set      = 1'b0;
      case (state_q)
         StLoad: begin
            if (load) begin
               short_set = 1'b1;
            end else if (cin_valid) begin
               for (int unsigned k = 0; k < COEFF_SIZE; k++) begin
                  if (word_count_q == CntW'(k)) begin
                     shadow_d[k*CoeffW +: CoeffW] = {cin_hi, cin_lo};
                  end
               end
               word_count_d = word_count_q + 1'b1;
            end
         end
         StFull: begin
            if (load) begin
               active_d = shadow_q;
               ready_d  = 1'b1;
            end else if (cin_valid) begin
               ovf_set = 1'b1;
            end
         end
         StRun, StError: begin
            if (!load) word_count_d = '0;
         end
         default: ;
      endcase
      // A new error event in the same cycle as err_clr keeps the flag set
      short_d = (short_q & ~err_clr) | short_set;
      ovf_d   = (ovf_q & ~err_clr) | ovf_set;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_count_q <= '0;
         shadow_q     <= '0;
         active_q     <= '0;
         ready_q      <= 1'b0;
         short_q      <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         word_count_q <= word_count_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         ready_q      <= ready_d;
         short_q      <= short_d;
         ovf_q        <= ovf_d;
      end
   end

   assign coeff_flat  = active_q;
   assign coeff_ready = ready_q;
   assign word_count  = word_count_q;
   assign short_err   = short_q;
   assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_fir_coeff_receiver.sv
// Bench for fir_coeff_receiver: directed load scenarios plus random traffic, all checked
// against a queue-based model of the load/commit protocol.
module tb_fir_coeff_receiver;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 16;
   localparam int unsigned FW = N * 2 * W;
   localparam logic [FW-1:0] BasicBank = 128'h7FFF0001_FFFFFFFF_00020000_00018000;

   logic            clk;
   logic            reset;
   logic            load;
   logic            cin_valid;
   logic [W-1:0]    cin_hi;
   logic [W-1:0]    cin_lo;
   logic            err_clr;
   logic [FW-1:0]   coeff_flat;
   logic            coeff_ready;
   logic [2:0]      word_count;
   logic            short_err;
   logic            ovf_err;

   fir_coeff_receiver #(
      .COEFF_SIZE (N),
      .WIDTH      (W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .cin_valid   (cin_valid),
      .cin_hi      (cin_hi),
      .cin_lo      (cin_lo),
      .err_clr     (err_clr),
      .coeff_flat  (coeff_flat),
      .coeff_ready (coeff_ready),
      .word_count  (word_count),
      .short_err   (short_err),
      .ovf_err     (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: words staged so far, committed bank, sticky flags, and whether the
   // receiver is currently accepting words (false after a commit or a short load).
   logic [2*W-1:0] staged[$];
   logic [FW-1:0]  m_flat;
   bit             m_ready, m_short, m_ovf, m_collect;

   task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic void model_reset();
      staged.delete();
      m_flat    = '0;
      m_ready   = 1'b0;
      m_short   = 1'b0;
      m_ovf     = 1'b0;
      m_collect = 1'b1;
   endfunction

   function automatic void model_step(input bit l, input bit v, input logic [W-1:0] hi,
                                      input logic [W-1:0] lo, input bit c);
      bit se = 1'b0;
      bit oe = 1'b0;
      if (m_collect) begin
         if (l) begin
            if (staged.size() == N) begin
               for (int k = 0; k < N; k++) m_flat[k*2*W +: 2*W] = staged[k];
               m_ready = 1'b1;
            end else begin
               se = 1'b1;
            end
            m_collect = 1'b0;
         end else if (v) begin
            if (staged.size() < N) staged.push_back({hi, lo});
            else oe = 1'b1;
         end
      end else if (!l) begin
         m_collect = 1'b1;
         staged.delete();
      end
      if (c) begin
         m_short = 1'b0;
         m_ovf   = 1'b0;
      end
      if (se) m_short = 1'b1;
      if (oe) m_ovf = 1'b1;
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".flat"},  coeff_flat, m_flat);
      check({tag, ".ready"}, FW'(coeff_ready), FW'(m_ready));
      check({tag, ".count"}, FW'(word_count), FW'(staged.size()));
      check({tag, ".short"}, FW'(short_err), FW'(m_short));
      check({tag, ".ovf"},   FW'(ovf_err), FW'(m_ovf));
   endtask

   task automatic step(input bit l, input bit v, input logic [W-1:0] hi, input logic [W-1:0] lo,
                       input bit c, input string tag);
      load      = l;
      cin_valid = v;
      cin_hi    = hi;
      cin_lo    = lo;
      err_clr   = c;
      @(posedge clk);
      model_step(l, v, hi, lo, c);
      #1;
      check_all(tag);
   endtask

   task automatic send_random_set(input string tag);
      for (int i = 0; i < N; i++) step(1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0, tag);
   endtask

   initial begin
      bit l_r;
      reset     = 1'b1;
      load      = 1'b0;
      cin_valid = 1'b0;
      cin_hi    = '0;
      cin_lo    = '0;
      err_clr   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      reset = 1'b0;

      // Basic load
      step(1'b0, 1'b1, 16'h0001, 16'h8000, 1'b0, "basic_w0");
      step(1'b0, 1'b1, 16'h0002, 16'h0000, 1'b0, "basic_w1");
      step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, "basic_w2");
      step(1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0, "basic_w3");
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, "basic_commit");
      check("basic_taps", coeff_flat, BasicBank);

      // Gapped reload: old bank stays visible until the new commit
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "gap_drop");
      step(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, "gap_w0");
      step(1'b0, 1'b0, 16'hDEAD, 16'hBEEF, 1'b0, "gap_idle0");
      step(1'b0, 1'b1, 16'h3333, 16'h4444, 1'b0, "gap_w1");
      check("gap_count", FW'(word_count), FW'(2));
      check("gap_old_bank", coeff_flat, BasicBank);
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "gap_idle1");
      step(1'b0, 1'b1, 16'h5555, 16'h6666, 1'b0, "gap_w2");
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "gap_idle2");
      step(1'b0, 1'b1, 16'h8765, 16'h4321, 1'b0, "gap_w3");
      step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, "gap_commit");
      check("gap_taps", coeff_flat, 128'h87654321_55556666_33334444_11112222);

      // Short sequence, with a word offered on the load cycle
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "short_drop");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0, "short_w");
      step(1'b1, 1'b1, 16'hAAAA, 16'hBBBB, 1'b0, "short_load");
      check("short_flag", FW'(short_err), FW'(1));
      check("short_count", FW'(word_count), FW'(3));
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "short_drop2");
      send_random_set("short_refill");
      step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, "short_commit");
      check("short_sticky", FW'(short_err), FW'(1));
      step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, "short_clr");
      check("short_cleared", FW'(short_err), FW'(0));

      // Overflow: fifth word dropped
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "ovf_drop");
      send_random_set("ovf_w");
      step(1'b0, 1'b1, 16'hCAFE, 16'hF00D, 1'b0, "ovf_w4");
      check("ovf_flag", FW'(ovf_err), FW'(1));
      check("ovf_count", FW'(word_count), FW'(4));
      step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, "ovf_commit");
      step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, "ovf_clr");
      check("ovf_cleared", FW'(ovf_err), FW'(0));

      // Overflow event coinciding with err_clr: the error wins
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "race_drop");
      send_random_set("race_w");
      step(1'b0, 1'b1, 16'h1234, 16'h5678, 1'b1, "race_ovf_clr");
      check("race_ovf", FW'(ovf_err), FW'(1));
      step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, "race_commit");

      // Asynchronous reset mid-reload, checked between edges
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "arst_drop");
      step(1'b0, 1'b1, 16'h0F0F, 16'hF0F0, 1'b0, "arst_w0");
      step(1'b0, 1'b1, 16'h1F1F, 16'hF1F1, 1'b0, "arst_w1");
      reset = 1'b1;
      #2;
      model_reset();
      check_all("arst");
      check("arst_ready", FW'(coeff_ready), FW'(0));
      reset = 1'b0;
      send_random_set("arst_refill");
      step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, "arst_commit");
      check("arst_ready_after", FW'(coeff_ready), FW'(1));

      // Random traffic
      l_r = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 7) == 0) l_r = !l_r;
         step(l_r, $urandom_range(0, 2) != 0, W'($urandom), W'($urandom),
              $urandom_range(0, 15) == 0, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
